// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state encodings, access-size codes and RAM geometry defaults
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  localparam int RAM_ADDR_BITS_DEF = 11;
  localparam int ROW_LAST_DEF      = 255;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of the low byte/half of a word; word passes through
module load_extend
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] word,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (size)
      SIZE_B:  data = zero_ext ? {24'b0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
      SIZE_H:  data = zero_ext ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding RV32 load/store unit in front of a word-write data RAM
// Optional row/region bound faulting is enabled by defining MEM_ACCESS_BOUND_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int ROW_LAST      = ROW_LAST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;

  logic        accept;
  logic        size_bad;
  logic        addr_in_range;
  logic        bound_fault;
  logic [31:0] ext_data;
  logic [31:0] merge_mask;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign size_bad  = (req_size == SIZE_BAD);

  // The RAM always touches 4 bytes, so the last legal row offset is ROW_LAST-3.
  assign addr_in_range = ({24'b0, req_addr[7:0]} <= 32'(ROW_LAST - 3)) &&
                         (req_addr[31:RAM_ADDR_BITS] == '0);

`ifdef MEM_ACCESS_BOUND_CHECK_EN
  assign bound_fault = !addr_in_range;
`else
  logic unused_addr_in_range;
  assign unused_addr_in_range = addr_in_range;
  assign bound_fault = 1'b0;
`endif

  load_extend u_load_ext (
    .size     (size_q),
    .zero_ext (uns_q),
    .word     (ram_dout),
    .data     (ext_data)
  );

  // Zero-extending all-ones yields the byte-lane mask of the store size.
  load_extend u_merge_mask (
    .size     (size_q),
    .zero_ext (1'b1),
    .word     (32'hFFFF_FFFF),
    .data     (merge_mask)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (size_bad || bound_fault)            state_next = ST_RESP;
          else if (req_we && req_size == SIZE_W)  state_next = ST_WR;
          else                                    state_next = ST_RD;
        end
      end
      ST_RD:      state_next = ST_RD_WAIT;
      ST_RD_WAIT: state_next = we_q ? ST_WR : ST_RESP;
      ST_WR:      state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      size_q  <= SIZE_B;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= req_addr;
        word_q  <= req_wdata;
        rdata_q <= '0;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= size_bad || bound_fault;
      end else if (state == ST_RD_WAIT) begin
        if (we_q) word_q  <= (word_q & merge_mask) | (ram_dout & ~merge_mask);
        else      rdata_q <= ext_data;
      end
    end
  end

  // RAM strobes are gated by rst_n so a reset cycle never reaches the array.
  assign ram_en     = rst_n && ((state == ST_RD) || (state == ST_WR));
  assign ram_rw     = rst_n && (state == ST_WR);
  assign ram_addr   = addr_q;
  assign ram_din    = word_q;

  assign resp_valid = rst_n && (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a registered-read RAM model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_en;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_en       (ram_en),
    .ram_rw       (ram_rw),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // RAM model: word stored per byte address, untouched locations return a preload table.
  logic [31:0] mem [0:255];
  logic [255:0] written = '0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wd = '0;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h20:   return 32'h0000_0080;
      8'h24:   return 32'h0000_8001;
      8'h30:   return 32'h1122_3344;
      8'h34:   return 32'hA5A5_A5A5;
      8'h40:   return 32'h5566_7788;
      8'hFE:   return 32'h0BAD_F00D;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] peek(input logic [7:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_rw) begin
        mem[ram_addr[7:0]]     <= ram_din;
        written[ram_addr[7:0]] <= 1'b1;
        wr_cnt                 <= wr_cnt + 1;
        last_wd                <= ram_din;
      end else begin
        ram_dout <= peek(ram_addr[7:0]);
        rd_cnt   <= rd_cnt + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          rd_end;
    int          wr_end;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp_valid", {31'b0, resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_err"},     {31'b0, resp_err}, {31'b0, e.err});
          check({e.name, "_rdata"},   resp_rdata, e.rdata);
          check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.name, "_reads"},   32'(rd_cnt), 32'(e.rd_end));
          check({e.name, "_writes"},  32'(wr_cnt), 32'(e.wr_end));
          if (e.chk_wd) check({e.name, "_ram_din"}, last_wd, e.wd);
        end
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input int nrd, input int nwr, input logic chk_wd, input logic [31:0] wd);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({name, "_accept_timeout"}, {31'b0, req_ready}, 32'd1);
    end else begin
      e.name = name; e.err = err; e.rdata = rdata; e.lat = lat; e.acc = cyc + 1;
      e.rd_end = rd_cnt + nrd; e.wr_end = wr_cnt + nwr; e.chk_wd = chk_wd; e.wd = wd;
      sb.push_back(e);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_ram_en"},     {31'b0, ram_en},     32'd0);
    check({tag, "_ram_rw"},     {31'b0, ram_rw},     32'd0);
  endtask

  initial begin
    int wr_before;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_ram_addr", ram_addr, 32'd0);
    check("reset_ram_din",  ram_din,  32'd0);
    rst_n = 1'b1;

    issue("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 0, 1, 1'b1, 32'hDEAD_BEEF);
    issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, 3, 1, 0, 1'b0, 32'h0);
    issue("lb_20",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0,         1'b0, 32'hFFFF_FF80, 3, 1, 0, 1'b0, 32'h0);
    issue("lbu_20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0,         1'b0, 32'h0000_0080, 3, 1, 0, 1'b0, 32'h0);
    issue("lh_24",  1'b0, 2'b01, 1'b0, 32'h24, 32'h0,         1'b0, 32'hFFFF_8001, 3, 1, 0, 1'b0, 32'h0);
    issue("lhu_24", 1'b0, 2'b01, 1'b1, 32'h24, 32'h0,         1'b0, 32'h0000_8001, 3, 1, 0, 1'b0, 32'h0);
    issue("sb_30",  1'b1, 2'b00, 1'b0, 32'h30, 32'hCAFE_00AA, 1'b0, 32'h0,         4, 1, 1, 1'b1, 32'h1122_33AA);
    issue("lw_30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0,         1'b0, 32'h1122_33AA, 3, 1, 0, 1'b0, 32'h0);
    issue("sh_34",  1'b1, 2'b01, 1'b0, 32'h34, 32'h1234_BEEF, 1'b0, 32'h0,         4, 1, 1, 1'b1, 32'hA5A5_BEEF);
    issue("lw_34",  1'b0, 2'b10, 1'b0, 32'h34, 32'h0,         1'b0, 32'hA5A5_BEEF, 3, 1, 0, 1'b0, 32'h0);
    issue("ld_bad", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         1'b1, 32'h0,         1, 0, 0, 1'b0, 32'h0);
    issue("st_bad", 1'b1, 2'b11, 1'b0, 32'h10, 32'h1111_1111, 1'b1, 32'h0,         1, 0, 0, 1'b0, 32'h0);
`ifdef MEM_ACCESS_BOUND_CHECK_EN
    issue("lw_fe",  1'b0, 2'b10, 1'b0, 32'hFE, 32'h0,         1'b1, 32'h0,         1, 0, 0, 1'b0, 32'h0);
`else
    issue("lw_fe",  1'b0, 2'b10, 1'b0, 32'hFE, 32'h0,         1'b0, 32'h0BAD_F00D, 3, 1, 0, 1'b0, 32'h0);
`endif
    drain();
    check("mem_30_after_sb", peek(8'h30), 32'h1122_33AA);

    // Reset while an SH sits in RD_WAIT: no write, no response, memory intact.
    wr_before = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ram_en_low", {31'b0, ram_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_abort");
    repeat (3) @(negedge clk);
    check("abort_no_write",   32'(wr_cnt), 32'(wr_before));
    check("abort_mem_40",     peek(8'h40), 32'h5566_7788);

    issue("lw_40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         1'b0, 32'h5566_7788, 3, 1, 0, 1'b0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
